riscv_irq_event_unit: RTL and testbench
=======================================

RISCV_IRQ_EVENT_UNIT -- requirements
Module: riscv_irq_event_unit

Interface
REQ-001 Parameter NUM_IRQ SHALL be: NUM_IRQ, 32, number of interrupt source lines; fixed at 32 because irq_id_o is 5 bits.
REQ-002 Port clk SHALL be: clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 Port rst_n SHALL be: rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port irq_src_i SHALL be: irq_src_i, input, 32, synchronous interrupt sources; a rising edge is an event.
REQ-005 Port irq_mask_i SHALL be: irq_mask_i, input, 32, per-line enable; 1 means enabled.
REQ-006 Port irq_sec_mask_i SHALL be: irq_sec_mask_i, input, 32, per-line secure attribute.
REQ-007 Port sw_set_i SHALL be: sw_set_i, input, 1, one-cycle software pend strobe.
REQ-008 Port sw_set_id_i SHALL be: sw_set_id_i, input, 5, line pended by sw_set_i.
REQ-009 Port irq_o SHALL be: irq_o, output, 1, level request to the core interrupt controller.
REQ-010 Port irq_id_o SHALL be: irq_id_o, output, 5, id of the presented interrupt.
REQ-011 Port irq_sec_o SHALL be: irq_sec_o, output, 1, secure bit of the presented interrupt.
REQ-012 Port irq_ack_i SHALL be: irq_ack_i, input, 1, one-cycle acknowledge from the core.
REQ-013 Port irq_ack_id_i SHALL be: irq_ack_id_i, input, 5, id being acknowledged.
REQ-014 Port pending_o SHALL be: pending_o, output, 32, pending register, for CSR readback.
REQ-015 Port ack_mismatch_o SHALL be: ack_mismatch_o, output, 1, one-cycle pulse when the acknowledged id differs from irq_id_o.

Function
REQ-016 A rising edge on line k (irq_src_i[k] 1 at edge t, 0 at edge t-1) SHALL set pending[k] at edge t, independent of the mask.
REQ-017 sw_set_i at edge t SHALL set pending[sw_set_id_i] at edge t.
REQ-018 An ack at edge t SHALL clear pending[irq_ack_id_i], unless a set event for the same bit occurs at edge t, in which case set wins.
REQ-019 Eligible lines SHALL be pending & irq_mask_i; the highest eligible index has priority.
REQ-020 The state machine SHALL have three states: IDLE, REQ and HOLD.
REQ-021 IDLE SHALL go to REQ at the next edge when any line is eligible, latching the winning id into id_q and irq_sec_mask_i[id] into sec_q.
REQ-022 In REQ, id_q and sec_q SHALL stay frozen; a later higher-priority event does not preempt, and mask changes do not withdraw the request.
REQ-023 REQ SHALL go to HOLD on irq_ack_i; without an ack it SHALL remain in REQ indefinitely.
REQ-024 HOLD SHALL last exactly 1 cycle and then return to IDLE, giving the core controller time to reach its idle state.
REQ-025 irq_o SHALL be 1 only in REQ.
REQ-026 irq_id_o and irq_sec_o SHALL always reflect id_q and sec_q.
REQ-027 sec_q SHALL clear to 0 on the HOLD-to-IDLE transition; id_q SHALL hold its value.
REQ-028 Latency: a source edge at edge t SHALL give pending_o high after edge t and irq_o high after edge t+1.
REQ-029 ack_mismatch_o SHALL pulse for 1 cycle when irq_ack_i is sampled in REQ with irq_ack_id_i != id_q; the state still goes to HOLD and pending[irq_ack_id_i] is still cleared.
REQ-030 irq_ack_i outside REQ SHALL clear the pending bit only, with no state change and no mismatch pulse.
REQ-031 After HOLD, remaining eligible lines SHALL be presented with minimum gap: irq_o low for 2 cycles (HOLD, IDLE).

Reset
REQ-032 While rst_n = 0, the block SHALL asynchronously force: state IDLE, pending 0, edge-history register 0, id_q 0, sec_q 0, irq_o 0, ack_mismatch_o 0.
REQ-033 A line held high across reset release SHALL register one event on the first edge after release, because history resets to 0.
REQ-034 Reset asserted mid-REQ SHALL drop irq_o immediately, and any unacknowledged events SHALL be lost.

Verification
REQ-035 Single event: mask=all-ones, rise on line 3 -> pending_o=0x8 next cycle; irq_o=1 with id 3 one cycle later; ack id 3 -> irq_o 0, pending_o=0.
REQ-036 Priority: lines 2 and 17 rise together -> id 17 presented first; after ack and a 2-cycle gap, id 2 presented.
REQ-037 Non-preemption: while id 5 is in REQ, line 30 rises -> id stays 5 until ack, then 30 is presented.
REQ-038 Masking: line 9 rises with mask[9]=0 -> pending_o[9]=1 and irq_o=0; set mask[9]=1 -> irq_o=1 with id 9; irq_sec_o equals sec_mask[9].
REQ-039 Collisions: ack id 4 in the same cycle as a new line-4 edge -> pending_o[4] stays 1 and is re-presented. Ack id 7 while presenting id 4 -> ack_mismatch_o pulses and pending[7] clears.
REQ-040 Reset while irq_o=1 and pending=0xFFFF0000 -> all outputs 0 asynchronously; no irq_o after release until a new edge occurs.

Source files
------------

// File: rtl/riscv_irq_event_unit_if.sv
// Request/acknowledge handshake between the interrupt event unit and the
// core interrupt controller.
//
// Signals:
//   irq_o        level request, high while an interrupt is presented
//   irq_id_o     id of the presented interrupt
//   irq_sec_o    secure attribute of the presented interrupt
//   irq_ack_i    one-cycle acknowledge from the core
//   irq_ack_id_i id being acknowledged
//
// Modports:
//   master  the event unit, which drives the request and receives the ack
//   slave   the core controller, which receives the request and drives the ack
interface riscv_irq_event_unit_if;
    logic       irq_o;
    logic [4:0] irq_id_o;
    logic       irq_sec_o;
    logic       irq_ack_i;
    logic [4:0] irq_ack_id_i;

    modport master (
        output irq_o,
        output irq_id_o,
        output irq_sec_o,
        input  irq_ack_i,
        input  irq_ack_id_i
    );

    modport slave (
        input  irq_o,
        input  irq_id_o,
        input  irq_sec_o,
        output irq_ack_i,
        output irq_ack_id_i
    );
endinterface

// File: rtl/riscv_irq_event_unit.sv
// Interrupt event unit. It collects rising-edge and software events into a
// pending register and presents the highest-priority enabled pending line to
// the core interrupt controller. A presented request is never preempted: it
// stays up until the core acknowledges it.
//
// Ports:
//   clk             single clock, rising edge
//   rst_n           asynchronous active-low reset
//   irq_src_i       interrupt sources; a 0->1 transition between edges is an event
//   irq_mask_i      per-line enable (1 = enabled)
//   irq_sec_mask_i  per-line secure attribute
//   sw_set_i        one-cycle software pend strobe
//   sw_set_id_i     line pended by sw_set_i
//   core            request/ack handshake (master side)
//   pending_o       pending register, for CSR readback
//   ack_mismatch_o  one-cycle pulse when an ack in REQ names the wrong id
module riscv_irq_event_unit #(
    parameter int unsigned NUM_IRQ = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IRQ-1:0]      irq_src_i,
    input  logic [NUM_IRQ-1:0]      irq_mask_i,
    input  logic [NUM_IRQ-1:0]      irq_sec_mask_i,
    input  logic                    sw_set_i,
    input  logic [4:0]              sw_set_id_i,
    riscv_irq_event_unit_if.master  core,
    output logic [NUM_IRQ-1:0]      pending_o,
    output logic                    ack_mismatch_o
);

    localparam int unsigned IdW = 5;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StHold
    } state_e;

    state_e               state_q;
    logic [NUM_IRQ-1:0]   pending_q;
    logic [NUM_IRQ-1:0]   pending_d;
    logic [NUM_IRQ-1:0]   src_q;      // source history for edge detection
    logic [IdW-1:0]       id_q;
    logic                 sec_q;
    logic                 irq_q;
    logic                 mismatch_q;

    logic [NUM_IRQ-1:0]   set_vec;
    logic [NUM_IRQ-1:0]   clr_vec;
    logic [NUM_IRQ-1:0]   eligible;
    logic                 win_valid;
    logic [IdW-1:0]       win_id;

    // ------------------------------------------------------------------
    // Pending register: hardware edges and software strobes set bits, the
    // acknowledge clears one bit. Set is applied after clear so a new event
    // on the acknowledged line in the same cycle is not lost.
    // ------------------------------------------------------------------
    always_comb begin
        set_vec = irq_src_i & ~src_q;
        clr_vec = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (sw_set_i && (sw_set_id_i == IdW'(i))) begin
                set_vec[i] = 1'b1;
            end
            if (core.irq_ack_i && (core.irq_ack_id_i == IdW'(i))) begin
                clr_vec[i] = 1'b1;
            end
        end
        pending_d = (pending_q & ~clr_vec) | set_vec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            src_q     <= '0;
        end else begin
            pending_q <= pending_d;
            src_q     <= irq_src_i;
        end
    end

    // ------------------------------------------------------------------
    // Priority select: highest enabled pending index wins. The loop runs
    // upward so later (higher) indices overwrite earlier ones.
    // ------------------------------------------------------------------
    always_comb begin
        eligible  = pending_q & irq_mask_i;
        win_valid = |eligible;
        win_id    = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (eligible[i]) begin
                win_id = IdW'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Presentation FSM with registered outputs. id/sec are latched on entry
    // to REQ and frozen there, so later events or mask changes cannot alter
    // or withdraw a request the core may already be servicing. HOLD is a
    // single dead cycle that lets the core controller return to idle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            id_q       <= '0;
            sec_q      <= 1'b0;
            irq_q      <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (win_valid) begin
                        state_q <= StReq;
                        id_q    <= win_id;
                        sec_q   <= irq_sec_mask_i[win_id];
                        irq_q   <= 1'b1;
                    end
                end
                StReq: begin
                    if (core.irq_ack_i) begin
                        state_q    <= StHold;
                        irq_q      <= 1'b0;
                        mismatch_q <= (core.irq_ack_id_i != id_q);
                    end
                end
                StHold: begin
                    // id_q is kept for readback; only the secure bit is scrubbed.
                    state_q <= StIdle;
                    sec_q   <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    assign core.irq_o     = irq_q;
    assign core.irq_id_o  = id_q;
    assign core.irq_sec_o = sec_q;
    assign pending_o      = pending_q;
    assign ack_mismatch_o = mismatch_q;

endmodule

// File: tb/tb_riscv_irq_event_unit.sv
module tb_riscv_irq_event_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] src = '0;
    logic [31:0] mask = '1;
    logic [31:0] secm = '0;
    logic        sw_set = 1'b0;
    logic [4:0]  sw_id = '0;
    logic [31:0] pend;
    logic        mis;

    riscv_irq_event_unit_if core_if ();

    riscv_irq_event_unit #(.NUM_IRQ(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .irq_src_i      (src),
        .irq_mask_i     (mask),
        .irq_sec_mask_i (secm),
        .sw_set_i       (sw_set),
        .sw_set_id_i    (sw_id),
        .core           (core_if),
        .pending_o      (pend),
        .ack_mismatch_o (mis)
    );

    always #5 clk = ~clk;

    // Behavioural model: pending set, "presenting" flag, one-cycle dead flag.
    bit [31:0] m_pend, m_hist;
    bit        m_irq, m_dead, m_mis, m_sec;
    bit [4:0]  m_id;

    int  n_cmp = 0;
    int  n_err = 0;
    bit  run_cmp = 1'b0;

    task automatic model_reset();
        m_pend = '0; m_hist = '0; m_irq = 0; m_dead = 0; m_mis = 0; m_sec = 0; m_id = '0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock: derive the next model state from the inputs that the
    // DUT will sample, then commit after the edge and drop one-cycle strobes.
    task automatic tick();
        bit [31:0] set, clr, elig, n_pend;
        bit        n_irq, n_dead, n_mis, n_sec;
        bit [4:0]  n_id;
        set = src & ~m_hist;
        if (sw_set) set[sw_id] = 1'b1;
        clr = '0;
        if (core_if.irq_ack_i) clr[core_if.irq_ack_id_i] = 1'b1;
        elig = m_pend & mask;
        n_irq = m_irq; n_dead = m_dead; n_id = m_id; n_sec = m_sec; n_mis = 0;
        if (m_irq) begin
            if (core_if.irq_ack_i) begin
                n_irq  = 0;
                n_dead = 1;
                n_mis  = (core_if.irq_ack_id_i != m_id);
            end
        end else if (m_dead) begin
            n_dead = 0;
            n_sec  = 0;
        end else if (elig != 0) begin
            for (int i = 0; i < 32; i++) if (elig[i]) n_id = 5'(i);
            n_sec = secm[n_id];
            n_irq = 1;
        end
        n_pend = (m_pend & ~clr) | set;
        @(posedge clk);
        m_pend = n_pend; m_hist = src; m_irq = n_irq; m_dead = n_dead;
        m_id = n_id; m_sec = n_sec; m_mis = n_mis;
        #1;
        sw_set = 1'b0;
        core_if.irq_ack_i = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic ack(input logic [4:0] id);
        core_if.irq_ack_i    = 1'b1;
        core_if.irq_ack_id_i = id;
    endtask

    // Assert reset mid-cycle, check outputs fall asynchronously, release on a
    // falling edge with src_rel applied to the sources.
    task automatic do_reset(input logic [31:0] src_rel);
        #2;
        rst_n = 1'b0;
        model_reset();
        sw_set = 1'b0;
        core_if.irq_ack_i = 1'b0;
        #1;
        chk("rst_irq", 32'(core_if.irq_o), 32'd0);
        chk("rst_id", 32'(core_if.irq_id_o), 32'd0);
        chk("rst_sec", 32'(core_if.irq_sec_o), 32'd0);
        chk("rst_pend", pend, 32'd0);
        chk("rst_mis", 32'(mis), 32'd0);
        src = src_rel;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (run_cmp) begin
            n_cmp++;
            if (core_if.irq_o !== m_irq || core_if.irq_id_o !== m_id ||
                core_if.irq_sec_o !== m_sec || pend !== m_pend || mis !== m_mis) begin
                n_err++;
                $display("FAIL model_cmp t=%0t got irq=%b id=%0d sec=%b pend=%h mis=%b expected irq=%b id=%0d sec=%b pend=%h mis=%b",
                         $time, core_if.irq_o, core_if.irq_id_o, core_if.irq_sec_o, pend, mis,
                         m_irq, m_id, m_sec, m_pend, m_mis);
            end
        end
    end

    initial begin
        core_if.irq_ack_i    = 1'b0;
        core_if.irq_ack_id_i = '0;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_cmp = 1'b1;

        // Single event on line 3.
        do_reset('0);
        mask = '1; secm = '0;
        tick();
        src = 32'h8; tick(); settle();
        chk("single_pend", pend, 32'h8);
        chk("single_irq_lat", 32'(core_if.irq_o), 32'd0);
        tick(); settle();
        chk("single_irq", 32'(core_if.irq_o), 32'd1);
        chk("single_id", 32'(core_if.irq_id_o), 32'd3);
        chk("model_pin_id", 32'(m_id), 32'd3);
        ack(5'd3); tick(); settle();
        chk("single_ack_irq", 32'(core_if.irq_o), 32'd0);
        chk("single_ack_pend", pend, 32'd0);

        // Priority: 17 before 2 with a 2-cycle gap.
        do_reset('0);
        tick();
        src = 32'h0002_0004; tick(); tick(); settle();
        chk("prio_first", 32'(core_if.irq_id_o), 32'd17);
        ack(5'd17); tick(); settle();
        chk("prio_gap1", 32'(core_if.irq_o), 32'd0);
        tick(); settle();
        chk("prio_gap2", 32'(core_if.irq_o), 32'd0);
        tick(); settle();
        chk("prio_second_irq", 32'(core_if.irq_o), 32'd1);
        chk("prio_second_id", 32'(core_if.irq_id_o), 32'd2);
        chk("prio_pend", pend, 32'h4);

        // Non-preemption: 30 arrives while 5 is presented.
        do_reset('0);
        tick();
        src = 32'h20; tick(); tick();
        src = 32'h4000_0020; tick(); settle();
        chk("nopre_id", 32'(core_if.irq_id_o), 32'd5);
        chk("nopre_pend", pend, 32'h4000_0020);
        ack(5'd5); tick(); tick(); tick(); settle();
        chk("nopre_next_irq", 32'(core_if.irq_o), 32'd1);
        chk("nopre_next_id", 32'(core_if.irq_id_o), 32'd30);

        // Masking and secure attribute.
        do_reset('0);
        mask = ~32'h200; secm = 32'h200;
        tick();
        src = 32'h200; tick(); tick(); settle();
        chk("mask_pend9", pend & 32'h200, 32'h200);
        chk("mask_irq", 32'(core_if.irq_o), 32'd0);
        mask = '1; tick(); settle();
        chk("mask_irq_on", 32'(core_if.irq_o), 32'd1);
        chk("mask_id", 32'(core_if.irq_id_o), 32'd9);
        chk("mask_sec", 32'(core_if.irq_sec_o), 32'd1);

        // Collisions: set beats ack on the same line; wrong-id ack.
        do_reset('0);
        secm = '0;
        tick();
        src = 32'h10; tick(); tick();
        src = 32'h0; tick();
        src = 32'h10; ack(5'd4); tick(); settle();
        chk("coll_pend4", pend, 32'h10);
        chk("coll_irq_off", 32'(core_if.irq_o), 32'd0);
        tick(); tick(); settle();
        chk("coll_repres", 32'(core_if.irq_id_o), 32'd4);
        chk("coll_repres_irq", 32'(core_if.irq_o), 32'd1);
        sw_set = 1'b1; sw_id = 5'd7; tick(); settle();
        chk("coll_sw7", pend, 32'h90);
        ack(5'd7); tick(); settle();
        chk("coll_mis", 32'(mis), 32'd1);
        chk("coll_mis_pend", pend, 32'h10);
        chk("coll_mis_irq", 32'(core_if.irq_o), 32'd0);
        tick(); settle();
        chk("coll_mis_pulse", 32'(mis), 32'd0);

        // Reset while presenting with pending 0xFFFF0000.
        do_reset('0);
        tick();
        src = 32'hFFFF_0000; tick(); tick(); settle();
        chk("rmid_irq", 32'(core_if.irq_o), 32'd1);
        chk("rmid_pend", pend, 32'hFFFF_0000);
        do_reset('0);
        tick(); tick(); tick(); settle();
        chk("rmid_quiet_irq", 32'(core_if.irq_o), 32'd0);
        chk("rmid_quiet_pend", pend, 32'd0);

        // Line held high across reset release gives one event.
        do_reset(32'h2);
        tick(); settle();
        chk("held_pend", pend, 32'h2);
        tick(); settle();
        chk("held_id", 32'(core_if.irq_id_o), 32'd1);
        ack(5'd1); tick(); tick(); tick(); tick(); settle();
        chk("held_once", 32'(core_if.irq_o), 32'd0);

        // Randomised traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) src = src ^ ($urandom & $urandom & $urandom);
            if ($urandom_range(0, 49) == 0) mask = $urandom | $urandom;
            if ($urandom_range(0, 49) == 0) secm = $urandom;
            sw_set = ($urandom_range(0, 9) == 0);
            sw_id  = 5'($urandom);
            if (m_irq && $urandom_range(0, 3) == 0) begin
                ack(($urandom_range(0, 4) == 0) ? 5'($urandom) : m_id);
            end else if ($urandom_range(0, 29) == 0) begin
                ack(5'($urandom));
            end
            if ($urandom_range(0, 1499) == 0) do_reset(src);
            tick();
        end
        settle();
        run_cmp = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
